// File: rtl/blink_cnt_pkg.sv
// Shared types, constants and helpers for the blink edge counter.
// Holds BCD/segment types, the digit-to-segment table (active-high) and a BCD increment.
// No ports; imported by blink_edge_counter and seg7_decoder.
package blink_cnt_pkg;

  typedef logic [3:0] bcd_t;
  typedef logic [6:0] seg7_t;   // {g,f,e,d,c,b,a}

  localparam seg7_t SEG_BLANK = 7'h00;

  // Active-high segment codes, index = digit 0..9.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F,  // 9
    7'h7F,  // 8
    7'h07,  // 7
    7'h7D,  // 6
    7'h6D,  // 5
    7'h66,  // 4
    7'h4F,  // 3
    7'h5B,  // 2
    7'h06,  // 1
    7'h3F   // 0
  };

  typedef struct packed {
    logic carry;
    bcd_t digit;
  } bcd_inc_t;

  // Next BCD digit; 9 (or anything illegal above it) rolls to 0 with carry.
  function automatic bcd_inc_t bcd_inc(input bcd_t d);
    bcd_inc_t r;
    if (d >= 4'd9) begin
      r.carry = 1'b1;
      r.digit = 4'd0;
    end else begin
      r.carry = 1'b0;
      r.digit = d + 4'd1;
    end
    return r;
  endfunction

  // Active-high segment pattern; codes 10..15 show blank.
  function automatic seg7_t seg7_encode(input bcd_t d);
    seg7_t s;
    if (d <= 4'd9) s = SEG_TABLE[d];
    else           s = SEG_BLANK;
    return s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Registered BCD to 7-segment decoder with selectable output polarity.
// Latency: 1 cycle from digit_i to seg_o. No backpressure.
// Ports: clk, rst_n (async active-low), digit_i (BCD), seg_o ({g,f,e,d,c,b,a}; resets to "0").
module seg7_decoder
  import blink_cnt_pkg::*;
#(
  parameter int ACTIVE_LOW = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  bcd_t  digit_i,
  output seg7_t seg_o
);

  localparam seg7_t ZERO_HI  = SEG_TABLE[0];
  localparam seg7_t RST_SEG  = (ACTIVE_LOW != 0) ? ~ZERO_HI : ZERO_HI;

  seg7_t seg_d, seg_q;

  always_comb begin
    seg_d = seg7_encode(digit_i);
    if (ACTIVE_LOW != 0) seg_d = ~seg_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) seg_q <= RST_SEG;
    else        seg_q <= seg_d;
  end

  assign seg_o = seg_q;

endmodule

// File: rtl/blink_edge_counter.sv
// Synchronizes and glitch-filters a blink level, counts its rising edges in 2-digit BCD.
// Latency: edge_pulse/count visible FILTER_CYCLES+3 edges after blink_in rises; segments +1.
// Ports: clk, rst_n, blink_in (async), en, clr -> ones, tens, edge_pulse, wrap_pulse, seg_ones, seg_tens.
// Macro BLINKCNT_SEG7_EN: when defined, seg_* carry registered decoded digits; else all-off.
module blink_edge_counter
  import blink_cnt_pkg::*;
#(
  parameter int FILTER_CYCLES  = 4,
  parameter int MAX_COUNT      = 99,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       blink_in,
  input  logic       en,
  input  logic       clr,
  output logic [3:0] ones,
  output logic [3:0] tens,
  output logic       edge_pulse,
  output logic       wrap_pulse,
  output logic [6:0] seg_ones,
  output logic [6:0] seg_tens
);

  if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max
    $error("MAX_COUNT must be in 1..99");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filt
    $error("FILTER_CYCLES must be in 1..255");
  end

  localparam bcd_t       MAX_TENS  = bcd_t'(MAX_COUNT / 10);
  localparam bcd_t       MAX_ONES  = bcd_t'(MAX_COUNT % 10);
  localparam logic [7:0] FCNT_LAST = 8'(FILTER_CYCLES - 1);

  logic       s1_q, s2_q;
  logic       filt_q, filt_d;
  logic       filt_prev_q;
  logic [7:0] fcnt_q, fcnt_d;
  logic       edge_det;
  logic       edge_q;
  logic       wrap_q, wrap_d;
  bcd_t       ones_q, ones_d;
  bcd_t       tens_q, tens_d;
  bcd_inc_t   ones_inc, tens_inc;

  // Filter: a new level must be seen on FILTER_CYCLES consecutive edges.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = 8'd0;
    if (s2_q != filt_q) begin
      if (fcnt_q == FCNT_LAST) begin
        filt_d = s2_q;
      end else begin
        fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  assign edge_det = filt_q & ~filt_prev_q;

  // BCD counter; clr wins over a coincident edge.
  always_comb begin
    ones_d   = ones_q;
    tens_d   = tens_q;
    wrap_d   = 1'b0;
    ones_inc = bcd_inc(ones_q);
    tens_inc = bcd_inc(tens_q);
    if (clr) begin
      ones_d = 4'd0;
      tens_d = 4'd0;
    end else if (edge_det && en) begin
      if (tens_q == MAX_TENS && ones_q == MAX_ONES) begin
        ones_d = 4'd0;
        tens_d = 4'd0;
        wrap_d = 1'b1;
      end else begin
        ones_d = ones_inc.digit;
        if (ones_inc.carry) tens_d = tens_inc.digit;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      fcnt_q      <= 8'd0;
      edge_q      <= 1'b0;
      wrap_q      <= 1'b0;
      ones_q      <= 4'd0;
      tens_q      <= 4'd0;
    end else begin
      s1_q        <= blink_in;
      s2_q        <= s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      fcnt_q      <= fcnt_d;
      edge_q      <= edge_det;
      wrap_q      <= wrap_d;
      ones_q      <= ones_d;
      tens_q      <= tens_d;
    end
  end

  assign ones       = ones_q;
  assign tens       = tens_q;
  assign edge_pulse = edge_q;
  assign wrap_pulse = wrap_q;

`ifdef BLINKCNT_SEG7_EN
  seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_ones (
    .clk     (clk),
    .rst_n   (rst_n),
    .digit_i (ones_q),
    .seg_o   (seg_ones)
  );
  seg7_decoder #(.ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_tens (
    .clk     (clk),
    .rst_n   (rst_n),
    .digit_i (tens_q),
    .seg_o   (seg_tens)
  );
`else
  assign seg_ones = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  assign seg_tens = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
`endif

endmodule

// File: tb/tb_blink_edge_counter.sv
module tb_blink_edge_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, blink_in, en, clr;
  logic [3:0] a_ones, a_tens, b_ones, b_tens;
  logic       a_edge, a_wrap, b_edge, b_wrap;
  logic [6:0] a_seg_o, a_seg_t, b_seg_o, b_seg_t;

  int errs   = 0;
  int checks = 0;

`ifdef BLINKCNT_SEG7_EN
  localparam logic [6:0] SEG_RST = 7'h40;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_0   = 7'h40;
`else
  localparam logic [6:0] SEG_RST = 7'h7F;
  localparam logic [6:0] SEG_7   = 7'h7F;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h7F;
`endif

  blink_edge_counter dut (
    .clk(clk), .rst_n(rst_n), .blink_in(blink_in), .en(en), .clr(clr),
    .ones(a_ones), .tens(a_tens), .edge_pulse(a_edge), .wrap_pulse(a_wrap),
    .seg_ones(a_seg_o), .seg_tens(a_seg_t)
  );

  blink_edge_counter #(.MAX_COUNT(12)) dut12 (
    .clk(clk), .rst_n(rst_n), .blink_in(blink_in), .en(en), .clr(clr),
    .ones(b_ones), .tens(b_tens), .edge_pulse(b_edge), .wrap_pulse(b_wrap),
    .seg_ones(b_seg_o), .seg_tens(b_seg_t)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; blink_in = 1'b0; en = 1'b1; clr = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic blink_pulse(input int hi, input int lo,
                             output int np, output int nw, output int nw12);
    np = 0; nw = 0; nw12 = 0;
    blink_in = 1'b1;
    repeat (hi) begin
      tick();
      np += int'(a_edge); nw += int'(a_wrap); nw12 += int'(b_wrap);
    end
    blink_in = 1'b0;
    repeat (lo) begin
      tick();
      np += int'(a_edge); nw += int'(a_wrap); nw12 += int'(b_wrap);
    end
  endtask

  task automatic test_reset();
    int extra;
    rst_n = 1'b0; blink_in = 1'b1; en = 1'b1; clr = 1'b0;
    #3;
    repeat (2) tick();
    checks++;
    if (a_ones !== 4'd0 || a_tens !== 4'd0 || a_edge !== 1'b0 || a_wrap !== 1'b0) begin
      errs++;
      $display("FAIL reset_outputs: got ones=%0d tens=%0d edge=%b wrap=%b, need all 0",
               a_ones, a_tens, a_edge, a_wrap);
    end
    checks++;
    if (a_seg_o !== SEG_RST || a_seg_t !== SEG_RST) begin
      errs++;
      $display("FAIL reset_segments: got %h/%h need %h", a_seg_t, a_seg_o, SEG_RST);
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      checks++;
      if (a_edge !== (k == 7)) begin
        errs++;
        $display("FAIL latency_edge_k%0d: got edge=%b need %b", k, a_edge, (k == 7));
      end
      if (k == 7) begin
        checks++;
        if (a_ones !== 4'd1 || a_tens !== 4'd0) begin
          errs++;
          $display("FAIL latency_count: got %0d%0d need 01", a_tens, a_ones);
        end
      end
    end
    extra = 0;
    repeat (10) begin
      tick();
      extra += int'(a_edge);
    end
    checks++;
    if (extra !== 0 || a_ones !== 4'd1) begin
      errs++;
      $display("FAIL held_high: got extra_pulses=%0d ones=%0d need 0 and 1", extra, a_ones);
    end
    // Asynchronous reset mid-cycle must clear at once.
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_ones !== 4'd0) begin
      errs++;
      $display("FAIL async_reset: got ones=%0d need 0", a_ones);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_glitch();
    int np, nw, nw12;
    do_reset();
    blink_pulse(6, 8, np, nw, nw12);
    blink_pulse(3, 8, np, nw, nw12);
    checks++;
    if (np !== 0 || a_ones !== 4'd1) begin
      errs++;
      $display("FAIL glitch_3cyc: got pulses=%0d ones=%0d need 0 and 1", np, a_ones);
    end
    blink_pulse(4, 8, np, nw, nw12);
    checks++;
    if (np !== 1 || a_ones !== 4'd2) begin
      errs++;
      $display("FAIL pulse_4cyc: got pulses=%0d ones=%0d need 1 and 2", np, a_ones);
    end
  endtask

  task automatic test_bcd_wrap();
    int np, nw, nw12, total_w, e;
    do_reset();
    total_w = 0;
    for (int i = 1; i <= 100; i++) begin
      blink_pulse(6, 8, np, nw, nw12);
      total_w += nw;
      e = i % 100;
      if (i == 9 || i == 10 || i == 98 || i == 99 || i == 100) begin
        checks++;
        if (a_tens !== 4'(e / 10) || a_ones !== 4'(e % 10)) begin
          errs++;
          $display("FAIL bcd_edge%0d: got %0d%0d need %0d%0d", i, a_tens, a_ones, e / 10, e % 10);
        end
      end
      if (i == 100) begin
        checks++;
        if (nw !== 1) begin
          errs++;
          $display("FAIL wrap_on_100th: got %0d wrap pulses need 1", nw);
        end
      end
    end
    checks++;
    if (total_w !== 1) begin
      errs++;
      $display("FAIL wrap_total: got %0d need 1", total_w);
    end
  endtask

  task automatic test_custom_terminal();
    int np, nw, nw12, e;
    do_reset();
    for (int i = 1; i <= 14; i++) begin
      blink_pulse(6, 8, np, nw, nw12);
      e = i % 13;
      checks++;
      if (b_tens !== 4'(e / 10) || b_ones !== 4'(e % 10) || nw12 !== int'(i == 13)) begin
        errs++;
        $display("FAIL max12_edge%0d: got %0d%0d wraps=%0d need %0d%0d wraps=%0d",
                 i, b_tens, b_ones, nw12, e / 10, e % 10, int'(i == 13));
      end
    end
  endtask

  task automatic test_en_clr();
    int np, nw, nw12;
    do_reset();
    blink_pulse(6, 8, np, nw, nw12);
    en = 1'b0;
    blink_pulse(6, 8, np, nw, nw12);
    en = 1'b1;
    checks++;
    if (np !== 1 || a_ones !== 4'd1) begin
      errs++;
      $display("FAIL en_low: got pulses=%0d ones=%0d need 1 and 1", np, a_ones);
    end
    repeat (36) blink_pulse(6, 8, np, nw, nw12);
    checks++;
    if (a_tens !== 4'd3 || a_ones !== 4'd7) begin
      errs++;
      $display("FAIL reach_37: got %0d%0d need 37", a_tens, a_ones);
    end
    blink_in = 1'b1;
    repeat (6) tick();
    clr = 1'b1;
    tick();
    checks++;
    if (a_tens !== 4'd0 || a_ones !== 4'd0 || a_wrap !== 1'b0) begin
      errs++;
      $display("FAIL clr_priority: got %0d%0d wrap=%b need 00 wrap=0", a_tens, a_ones, a_wrap);
    end
    clr = 1'b0;
    blink_in = 1'b0;
    repeat (8) tick();
    checks++;
    if (a_tens !== 4'd0 || a_ones !== 4'd0) begin
      errs++;
      $display("FAIL clr_edge_dropped: got %0d%0d need 00", a_tens, a_ones);
    end
  endtask

  task automatic test_segments();
    int np, nw, nw12;
    do_reset();
    repeat (7) blink_pulse(6, 8, np, nw, nw12);
    blink_in = 1'b1;
    repeat (7) tick();
    checks++;
    if (a_ones !== 4'd8 || a_seg_o !== SEG_7) begin
      errs++;
      $display("FAIL seg_before: got ones=%0d seg=%h need 8 and %h", a_ones, a_seg_o, SEG_7);
    end
    tick();
    checks++;
    if (a_seg_o !== SEG_8 || a_seg_t !== SEG_0) begin
      errs++;
      $display("FAIL seg_08: got tens=%h ones=%h need %h %h", a_seg_t, a_seg_o, SEG_0, SEG_8);
    end
    blink_in = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst_n = 1'b0; blink_in = 1'b0; en = 1'b1; clr = 1'b0;
    test_reset();
    test_glitch();
    test_bcd_wrap();
    test_custom_terminal();
    test_en_clr();
    test_segments();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
